// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with busy-bit scoreboard and N-stage bypass; x0 reads as zero.
// Optional macro REGFILE_SCRUB_EN: after reset, clear the array one register per cycle instead of all at once.
//
// state | meaning
// INIT  | array being cleared; writes/issues ignored, reads invalid, stall forced
// RUN   | normal operand service, writeback and issue tracking
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int NBYP = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_init_done,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [XLEN-1:0]      i_wdata,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_rd,
    input  logic                 i_flush,
    input  logic [NBYP-1:0]      i_byp_valid,
    input  logic [NBYP*AW-1:0]   i_byp_addr,
    input  logic [NBYP*XLEN-1:0] i_byp_data,
    input  logic [NRD-1:0]       i_re,
    input  logic [NRD*AW-1:0]    i_raddr,
    output logic [NRD*XLEN-1:0]  o_rdata,
    output logic [NRD-1:0]       o_rvalid,
    output logic                 o_stall
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_run;
    logic            w_wr_en;
    logic            w_iss_en;
    logic            w_init_last;

    assign w_run    = (r_state == ST_RUN);
    assign w_wr_en  = w_run && i_we && (i_waddr != '0);
    assign w_iss_en = w_run && i_iss_valid && (i_iss_rd != '0);

`ifdef REGFILE_SCRUB_EN
    logic [AW-1:0] r_scrub_cnt;
    logic [AW-1:0] w_scrub_addr;

    // Counter holds the last register cleared; x0 is never scrubbed since it is never read.
    assign w_scrub_addr = r_scrub_cnt + AW'(1);
    assign w_init_last  = (w_scrub_addr == AW'(NREG - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_scrub_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_scrub_cnt <= w_init_last ? '0 : w_scrub_addr;
        end
    end
`else
    assign w_init_last = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign o_init_done = w_run;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
`ifndef REGFILE_SCRUB_EN
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
`endif
        end else if (r_state == ST_INIT) begin
`ifdef REGFILE_SCRUB_EN
            r_regs[w_scrub_addr] <= '0;
`endif
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Order matters: flush, then writeback clear, then issue set so a new producer always wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end
        if (w_wr_en) begin
            w_busy_nxt[i_waddr] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_nxt[i_iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_busy <= '0;
        end else if (w_run) begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        logic [AW-1:0] v_ra;
        logic          v_hit;
        o_rdata  = '0;
        o_rvalid = '0;
        v_ra     = '0;
        v_hit    = 1'b0;
        for (int j = 0; j < NRD; j++) begin
            v_ra  = i_raddr[j*AW +: AW];
            v_hit = 1'b0;
            if (!w_run) begin
                o_rvalid[j] = 1'b0;
            end else if (!i_re[j] || (v_ra == '0)) begin
                o_rvalid[j] = 1'b1;
            end else begin
                // Youngest matching stage wins.
                for (int i = 0; i < NBYP; i++) begin
                    if (!v_hit && i_byp_valid[i] && (i_byp_addr[i*AW +: AW] == v_ra)) begin
                        v_hit = 1'b1;
                        o_rdata[j*XLEN +: XLEN] = i_byp_data[i*XLEN +: XLEN];
                    end
                end
                if (v_hit) begin
                    o_rvalid[j] = 1'b1;
                end else if (i_we && (i_waddr == v_ra)) begin
                    o_rdata[j*XLEN +: XLEN] = i_wdata;
                    o_rvalid[j]             = 1'b1;
                end else if (r_busy[v_ra]) begin
                    o_rvalid[j] = 1'b0;
                end else begin
                    o_rdata[j*XLEN +: XLEN] = r_regs[v_ra];
                    o_rvalid[j]             = 1'b1;
                end
            end
        end
    end

    assign o_stall = !w_run || (|(i_re & ~o_rvalid));

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven vectors through a scoreboard queue, plus reset/INIT-length sequences.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int NBYP = 2;
`ifdef REGFILE_SCRUB_EN
    localparam int INIT_LEN = NREG - 1;
`else
    localparam int INIT_LEN = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 init_done;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [XLEN-1:0]      wdata;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 flush;
    logic [NBYP-1:0]      byp_valid;
    logic [NBYP*AW-1:0]   byp_addr;
    logic [NBYP*XLEN-1:0] byp_data;
    logic [NRD-1:0]       re;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic [NRD-1:0]       rvalid;
    logic                 stall;

    int n_checks = 0;
    int n_err    = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NBYP(NBYP)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .o_init_done (init_done),
        .i_we        (we),
        .i_waddr     (waddr),
        .i_wdata     (wdata),
        .i_iss_valid (iss_valid),
        .i_iss_rd    (iss_rd),
        .i_flush     (flush),
        .i_byp_valid (byp_valid),
        .i_byp_addr  (byp_addr),
        .i_byp_data  (byp_data),
        .i_re        (re),
        .i_raddr     (raddr),
        .o_rdata     (rdata),
        .o_rvalid    (rvalid),
        .o_stall     (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ird;
        logic        fl;
        logic [1:0]  bv;
        logic [4:0]  ba0;
        logic [31:0] bd0;
        logic [4:0]  ba1;
        logic [31:0] bd1;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
        logic [1:0]  e_v;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  v;
        logic        stall;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(input int we_i, input int wa, input logic [31:0] wd,
                                input int iss, input int ird, input int fl,
                                input int bv, input int ba0, input logic [31:0] bd0,
                                input int ba1, input logic [31:0] bd1,
                                input int re_i, input int ra0, input int ra1,
                                input logic [31:0] ed0, input logic [31:0] ed1,
                                input int ev, input int es);
        vec_t v;
        v.we = 1'(we_i);  v.wa = 5'(wa);   v.wd = wd;
        v.iss = 1'(iss);  v.ird = 5'(ird); v.fl = 1'(fl);
        v.bv = 2'(bv);    v.ba0 = 5'(ba0); v.bd0 = bd0; v.ba1 = 5'(ba1); v.bd1 = bd1;
        v.re = 2'(re_i);  v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.e_d0 = ed0;     v.e_d1 = ed1;    v.e_v = 2'(ev); v.e_stall = 1'(es);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic set_idle();
        we = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
        byp_valid = '0; byp_addr = '0; byp_data = '0;
        re = '0; raddr = '0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        we = v.we; waddr = v.wa; wdata = v.wd;
        iss_valid = v.iss; iss_rd = v.ird; flush = v.fl;
        byp_valid = v.bv; byp_addr = {v.ba1, v.ba0}; byp_data = {v.bd1, v.bd0};
        re = v.re; raddr = {v.ra1, v.ra0};
        e.d0 = v.e_d0; e.d1 = v.e_d1; e.v = v.e_v; e.stall = v.e_stall; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({e.name, "_rdata0"}, rdata[31:0], e.d0);
        chk({e.name, "_rdata1"}, rdata[63:32], e.d1);
        chk({e.name, "_rvalid"}, {30'd0, rvalid}, {30'd0, e.v});
        chk({e.name, "_stall"}, {31'd0, stall}, {31'd0, e.stall});
    endtask

    // Hold reset low for n edges with a write/issue pending, release, and time INIT.
    task automatic do_reset(input int n, input string tag);
        int cnt;
        logic seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        we = 1'b1; waddr = 5'd5; wdata = 32'h0000_0055;
        iss_valid = 1'b1; iss_rd = 5'd6;
        re = 2'b11; raddr = {5'd6, 5'd5};
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (init_done) begin
                seen = 1'b1;
            end else begin
                if (cnt == 0) begin
                    chk({tag, "_init_stall"}, {31'd0, stall}, 32'd1);
                    chk({tag, "_init_rvalid"}, {30'd0, rvalid}, 32'd0);
                    chk({tag, "_init_rdata"}, rdata[31:0] | rdata[63:32], 32'd0);
                end
                cnt++;
            end
        end
        set_idle();
        chk({tag, "_init_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            chk({tag, "_init_len"}, 32'(cnt), 32'(INIT_LEN));
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b0;

        //          we wa wd            iss ird fl bv ba0 bd0           ba1 bd1           re ra0 ra1  ed0           ed1           ev es
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            3, 5, 6,  0,            0,            3, 0));
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,            0, 0,            1, 5, 0,  32'hDEADBEEF, 0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            3, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 3, 0));
        vecs.push_back(mk(0, 0, 0,            1, 7, 0, 0, 0, 0,            0, 0,            1, 7, 0,  0,            0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            1, 7, 0,  0,            0,            2, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 2, 0, 0,            7, 32'h11,       1, 7, 0,  32'h11,       0,            3, 0));
        vecs.push_back(mk(1, 3, 32'hCCCC,     0, 0, 0, 3, 3, 32'hAAAA,     3, 32'hBBBB,     3, 3, 3,  32'hAAAA,     32'hAAAA,     3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            3, 3, 7,  32'hCCCC,     0,            1, 1));
        vecs.push_back(mk(1, 7, 32'h77,       0, 0, 0, 0, 0, 0,            0, 0,            3, 5, 7,  32'hDEADBEEF, 32'h77,       3, 0));
        vecs.push_back(mk(0, 0, 0,            1, 4, 0, 0, 0, 0,            0, 0,            3, 7, 7,  32'h77,       32'h77,       3, 0));
        vecs.push_back(mk(0, 0, 0,            1, 9, 1, 0, 0, 0,            0, 0,            1, 4, 0,  0,            0,            2, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            3, 4, 9,  0,            0,            1, 1));
        vecs.push_back(mk(1, 9, 32'h42,       1, 9, 0, 0, 0, 0,            0, 0,            1, 9, 0,  32'h42,       0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 1, 0, 0, 0,            0, 0,            1, 9, 0,  0,            0,            2, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            1, 9, 0,  32'h42,       0,            3, 0));
        vecs.push_back(mk(1, 0, 32'hFFFF,     1, 0, 0, 0, 0, 0,            0, 0,            3, 0, 0,  0,            0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            1, 4, 0, 0, 0, 0,            0, 0,            3, 0, 0,  0,            0,            3, 0));
        vecs.push_back(mk(1, 4, 32'h1234,     0, 0, 1, 0, 0, 0,            0, 0,            1, 4, 0,  32'h1234,     0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            3, 4, 0,  32'h1234,     0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            1, 6, 0, 0, 0, 0,            0, 0,            0, 0, 0,  0,            0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            0, 6, 6,  0,            0,            3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 0, 0, 0,            0, 0,            2, 6, 6,  0,            0,            1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 1, 6, 32'h66,       0, 0,            3, 6, 6,  32'h66,       32'h66,       3, 0));
        vecs.push_back(mk(1, 6, 32'h600,      0, 0, 0, 2, 0, 0,            5, 32'h555,      3, 6, 5,  32'h600,      32'h555,      3, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0, 1, 8, 32'h999,      0, 0,            3, 6, 8,  32'h600,      32'h999,      3, 0));
        vecs.push_back(mk(0, 0, 0,            1, 10, 0, 0, 0, 0,           0, 0,            0, 0, 0,  0,            0,            3, 0));

        do_reset(2, "rst0");

        for (int k = 0; k < NREG; k++) begin
            run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, k, NREG - 1 - k, 0, 0, 3, 0),
                    $sformatf("clr%0d", k));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset again part-way through INIT (counter near 10 when scrubbing); full INIT must repeat.
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (9) @(posedge clk);
        do_reset(1, "rst1");

        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 7,  0, 0, 3, 0), "post_x5x7");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 9, 10, 0, 0, 3, 0), "post_x9x10");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 6,  0, 0, 3, 0), "post_x4x6");
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 8,  0, 0, 3, 0), "post_x3x8");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
